cic_decimator: RTL and testbench
================================

Name: cic_decimator

Overview:
- Integer-ratio CIC decimator directly downstream of the notch filter stage in the DFE chain.
- Consumes the notch output as a 16-bit signed sample stream qualified by a per-sample strobe.
- Decimates by R using an N-stage CIC filter, then removes the R^N gain by shifting, giving a unity-DC-gain 16-bit signed output with its own strobe.
- Runs on the single system clock. No clock division inside the block; all rate changes are done with strobes.

Parameters:
- DATA_WIDTH, 16, input/output sample width (two's complement).
- R, 4, decimation ratio; must be a power of two, 2..16.
- N, 3, number of integrator and comb stages, 1..5.
- LOG2R, 2, log2(R); must be consistent with R.
- ACC_WIDTH, DATA_WIDTH+N*LOG2R (22), internal integrator/comb width.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- data_in  in  DATA_WIDTH  signed input sample (notch output).
- valid_in  in  1  data_in qualifier, one-cycle pulse per sample.
- data_out  out  DATA_WIDTH  signed decimated sample.
- valid_out  out  1  one-cycle pulse per output sample.

Behaviour:
- Reset: RST sampled high at an edge clears the following to 0:
  - all integrator, comb and comb-delay registers;
  - phase counter, comb valid pipeline, data_out, valid_out.
- RST has priority over valid_in at the same edge.
- Reset mid-operation discards all partial state. The first valid_out after reset requires R new accepted samples.
- Integrators:
  - Update only on edges where valid_in=1: int1 += sign_ext(data_in); int_k += int_(k-1) (new value of the previous stage).
  - Wrap-around modulo 2^ACC_WIDTH is intended and required; never saturate.
  - valid_in=0: all integrators hold.
- Phase counter:
  - Counts accepted samples 0..R-1 and wraps to 0.
  - An accepted sample with phase==R-1 asserts the internal strobe dec_stb for the following cycle. This is the edge at which int_N holds the decimated value.
- Comb section:
  - N pipelined stages, differential delay M=1.
  - Stage k registers c_k = x_k - x_k_prev and updates x_k_prev <= x_k one edge after stage k-1's valid.
  - Stages update only when their valid bit is set; otherwise they hold.
  - Subtraction is modulo 2^ACC_WIDTH.
- Output stage:
  - Default scaling truncates: data_out = c_N[ACC_WIDTH-1 : N*LOG2R].
  - Registered one edge after the stage-N valid, with valid_out=1 for exactly one cycle.
- Latency: from the edge accepting the R-th sample of a group to valid_out rising is N+2 edges (5 for defaults). data_out holds between pulses.
- Throughput: valid_in may be high every cycle. The comb pipeline (N+1 deep) never overlaps, since R>=2 strobes are at least R cycles apart. valid_in may also be arbitrarily sparse.
- DC gain: exactly 1 after N output samples of settling. A constant input x yields data_out=x, including +32767 and -32768.

Optional Feature:
- Macro: CIC_ROUND_EN.
- Defined: the output stage adds 2^(N*LOG2R-1) to c_N before the shift (round half up). It then saturates the result to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Latency is unchanged.
- Undefined: plain truncation as above; no rounding adder, no saturation logic.

Test Plan:
- Impulse: R=4, N=3; one sample 64 then zeros, valid_in every cycle -> outputs 10, 6, 0, 0… The first pulse arrives 5 edges after the 4th accepted sample.
- DC: constant 1000 with valid_in every second cycle -> outputs 1000 from the 3rd output onward. Repeat with 32767 and -32768 -> exact full-scale values, no wrap.
- Rounding: impulse 100 -> truncation gives 15, 9; with CIC_ROUND_EN gives 16, 9.
- Gapped strobes: random valid_in gaps of 0..7 cycles -> output sequence identical to the gapless run. valid_out count equals floor(accepted/4).
- Reset mid-stream: assert RST for 1 cycle after 6 samples (phase 2) -> all outputs 0 and valid_out low next cycle. The next valid_out follows 4 fresh samples, matching a fresh-start impulse/DC run.
- Simultaneous RST and valid_in: the sample is ignored, and the phase counter is 0 after the edge.

Source files
------------

// File: rtl/cic_decimator.sv
// N-stage, ratio-R CIC decimator with shift-based gain removal; unity DC gain.
// Optional feature macro CIC_ROUND_EN: round-half-up plus saturation at the output.
module cic_decimator #(
    parameter int DATA_WIDTH = 16,
    parameter int R          = 4,
    parameter int N          = 3,
    parameter int LOG2R      = 2,
    parameter int ACC_WIDTH  = DATA_WIDTH + N * LOG2R
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic                         valid_in,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         valid_out
);

    localparam int SHIFT = N * LOG2R;

    logic [ACC_WIDTH-1:0] r_int     [N];
    logic [ACC_WIDTH-1:0] w_int_nxt [N];
    logic [ACC_WIDTH-1:0] r_comb    [N];
    logic [ACC_WIDTH-1:0] r_dly     [N];
    logic [ACC_WIDTH-1:0] w_cin     [N];
    logic [ACC_WIDTH-1:0] r_x0;
    logic [ACC_WIDTH-1:0] w_ext;
    logic [ACC_WIDTH-1:0] w_acc;
    logic [LOG2R-1:0]     r_phase;
    logic                 r_dec_stb;
    logic [N:0]           r_cvld;
    logic [DATA_WIDTH-1:0] w_out;

    assign w_ext = {{SHIFT{data_in[DATA_WIDTH-1]}}, data_in};

    // Each integrator sees the already-updated previous stage, i.e. a running sum.
    always_comb begin
        w_acc = w_ext;
        for (int k = 0; k < N; k++) begin
            w_acc        = w_acc + r_int[k];
            w_int_nxt[k] = w_acc;
        end
    end

    always_comb begin
        w_cin[0] = r_x0;
        for (int k = 1; k < N; k++) begin
            w_cin[k] = r_comb[k-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < N; k++) begin
                r_int[k] <= '0;
            end
            r_phase   <= '0;
            r_dec_stb <= 1'b0;
        end else begin
            r_dec_stb <= valid_in && (r_phase == LOG2R'(R - 1));
            if (valid_in) begin
                for (int k = 0; k < N; k++) begin
                    r_int[k] <= w_int_nxt[k];
                end
                r_phase <= r_phase + 1'b1;
            end
        end
    end

    // r_cvld[0] qualifies the sampled int_N, r_cvld[k+1] qualifies comb stage k.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_x0   <= '0;
            r_cvld <= '0;
            for (int k = 0; k < N; k++) begin
                r_comb[k] <= '0;
                r_dly[k]  <= '0;
            end
        end else begin
            r_cvld <= {r_cvld[N-1:0], r_dec_stb};
            if (r_dec_stb) begin
                r_x0 <= r_int[N-1];
            end
            for (int k = 0; k < N; k++) begin
                if (r_cvld[k]) begin
                    r_comb[k] <= w_cin[k] - r_dly[k];
                    r_dly[k]  <= w_cin[k];
                end
            end
        end
    end

`ifdef CIC_ROUND_EN
    localparam logic signed [ACC_WIDTH:0] RND = (ACC_WIDTH + 1)'(1) <<< (SHIFT - 1);
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH:0]   w_rnd_sum;
    logic        [DATA_WIDTH:0]  w_rnd_top;
    logic                        w_unused_lsb;

    assign w_rnd_sum    = $signed({r_comb[N-1][ACC_WIDTH-1], r_comb[N-1]}) + RND;
    assign w_rnd_top    = w_rnd_sum[ACC_WIDTH:SHIFT];
    assign w_unused_lsb = ^w_rnd_sum[SHIFT-1:0];

    always_comb begin
        w_out = w_rnd_top[DATA_WIDTH-1:0];
        if (w_rnd_top[DATA_WIDTH] != w_rnd_top[DATA_WIDTH-1]) begin
            w_out = w_rnd_top[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    logic w_unused_lsb;

    assign w_out        = r_comb[N-1][ACC_WIDTH-1:SHIFT];
    assign w_unused_lsb = ^r_comb[N-1][SHIFT-1:0];
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= r_cvld[N];
            if (r_cvld[N]) begin
                data_out <= w_out;
            end
        end
    end

endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench for cic_decimator: FIR-equivalent reference model, timing and value checks.
module tb_cic_decimator;

    localparam int DW = 16;
    localparam int R  = 4;
    localparam int N  = 3;
    localparam int SH = 6;   // N*log2(R)
    localparam int LAT = 6;  // accept edge + 5 edges, observed at the following negedge

    logic                 CLK = 1'b0;
    logic                 RST = 1'b1;
    logic                 valid_in = 1'b0;
    logic signed [DW-1:0] data_in = '0;
    logic signed [DW-1:0] data_out;
    logic                 valid_out;

    cic_decimator dut (
        .CLK      (CLK),
        .RST      (RST),
        .data_in  (data_in),
        .valid_in (valid_in),
        .data_out (data_out),
        .valid_out(valid_out)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int val;
        int when;
    } exp_t;

    exp_t sbq[$];
    int   hist[$];
    int   h[$];
    int   cap[$];
    int   cap_a[$];
    int   stim[$];
    int   checks = 0;
    int   errors = 0;
    exp_t mon_e;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // CIC == FIR with (1 + z^-1 + ... + z^-(R-1))^N, decimated, divided by R^N.
    function automatic int expected_out();
        int n = hist.size();
        longint y = 0;
        for (int k = 0; k < h.size(); k++) begin
            if (n - 1 - k >= 0) y += longint'(h[k]) * hist[n-1-k];
        end
`ifdef CIC_ROUND_EN
        y = (y + (1 << (SH - 1))) >>> SH;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
`else
        y = y >>> SH;
`endif
        return int'(y);
    endfunction

    task automatic drive(input logic v, input int d, input logic rst);
        int e;
        exp_t x;
        RST      = rst;
        valid_in = v;
        data_in  = DW'(d);
        @(posedge CLK);
        e = cyc;
        if (rst) begin
            hist.delete();
            sbq.delete();
        end else if (v) begin
            hist.push_back(d);
            if (hist.size() % R == 0) begin
                x.val  = expected_out();
                x.when = e + LAT;
                sbq.push_back(x);
            end
        end
        #1;
        RST      = 1'b0;
        valid_in = 1'b0;
    endtask

    task automatic do_reset(input string name);
        drive(1'b0, 0, 1'b1);
        check({name, " data_out"}, int'(data_out), 0);
        check({name, " valid_out"}, int'(valid_out), 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0);
    endtask

    always @(negedge CLK) begin
        if (sbq.size() > 0 && sbq[0].when < cyc) begin
            mon_e = sbq.pop_front();
            check("missing valid_out cycle", cyc, mon_e.when);
        end
        if (valid_out === 1'b1) begin
            cap.push_back(int'(data_out));
            if (sbq.size() == 0) begin
                check("unexpected valid_out", 1, 0);
            end else begin
                mon_e = sbq.pop_front();
                check("data_out", int'(data_out), mon_e.val);
                check("latency", cyc, mon_e.when);
            end
        end
    end

    initial begin
        int tmp[$];
        h.push_back(1);
        for (int s = 0; s < N; s++) begin
            tmp.delete();
            for (int i = 0; i < h.size() + R - 1; i++) tmp.push_back(0);
            for (int i = 0; i < h.size(); i++)
                for (int j = 0; j < R; j++) tmp[i+j] += h[i];
            h = tmp;
        end

        RST = 1'b1;
        @(posedge CLK);
        #1;
        do_reset("reset");

        // Impulse 64
        cap.delete();
        drive(1'b1, 64, 1'b0);
        for (int i = 0; i < 15; i++) drive(1'b1, 0, 1'b0);
        idle(8);
        check("impulse64 count", cap.size(), 4);
        if (cap.size() >= 3) begin
            check("impulse64 out0", cap[0], 10);
            check("impulse64 out1", cap[1], 6);
            check("impulse64 out2", cap[2], 0);
        end

        // Impulse 100
        do_reset("reset2");
        cap.delete();
        drive(1'b1, 100, 1'b0);
        for (int i = 0; i < 7; i++) drive(1'b1, 0, 1'b0);
        idle(8);
        check("impulse100 count", cap.size(), 2);
        if (cap.size() >= 2) begin
`ifdef CIC_ROUND_EN
            check("impulse100 out0", cap[0], 16);
`else
            check("impulse100 out0", cap[0], 15);
`endif
            check("impulse100 out1", cap[1], 9);
        end

        // DC levels, valid_in every second cycle
        foreach (tmp[i]) tmp[i] = 0;
        tmp = '{1000, 32767, -32768};
        foreach (tmp[t]) begin
            do_reset("reset dc");
            cap.delete();
            for (int i = 0; i < 24; i++) begin
                drive(1'b1, tmp[t], 1'b0);
                drive(1'b0, 0, 1'b0);
            end
            idle(8);
            check("dc count", cap.size(), 6);
            for (int i = 2; i < cap.size(); i++) check("dc value", cap[i], tmp[t]);
        end

        // Random samples, gapless run then gapped run, outputs must match
        stim.delete();
        for (int i = 0; i < 202; i++) stim.push_back(int'($signed(16'($urandom))));
        do_reset("reset rnd");
        cap.delete();
        foreach (stim[i]) drive(1'b1, stim[i], 1'b0);
        idle(8);
        cap_a = cap;
        check("gapless count", cap_a.size(), 202 / R);
        do_reset("reset gap");
        cap.delete();
        foreach (stim[i]) begin
            drive(1'b1, stim[i], 1'b0);
            idle($urandom_range(0, 7));
        end
        idle(8);
        check("gapped count", cap.size(), 202 / R);
        if (cap.size() == cap_a.size())
            foreach (cap[i]) check("gapped vs gapless", cap[i], cap_a[i]);

        // Reset mid-stream at phase 2
        do_reset("reset mid pre");
        for (int i = 0; i < 6; i++) drive(1'b1, 3000 + i * 111, 1'b0);
        do_reset("reset mid");
        cap.delete();
        for (int i = 0; i < 8; i++) drive(1'b1, 500, 1'b0);
        idle(8);
        check("post-reset count", cap.size(), 2);
        if (cap.size() >= 1) check("post-reset out0", cap[0], (500 * 20) >>> SH);

        // RST together with valid_in: sample ignored, phase restarts
        drive(1'b1, 20000, 1'b1);
        check("rst+valid data_out", int'(data_out), 0);
        check("rst+valid valid_out", int'(valid_out), 0);
        cap.delete();
        for (int i = 0; i < 4; i++) drive(1'b1, 0, 1'b0);
        idle(8);
        check("rst+valid count", cap.size(), 1);
        if (cap.size() >= 1) check("rst+valid out0", cap[0], 0);

        // Random sparse traffic against the model
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, int'($signed(16'($urandom))), 1'b0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 5));
        end
        idle(12);
        check("scoreboard drained", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
